// File: rtl/sub_word.sv
// AES SubWord: forward S-box applied to each byte lane of a word.
// word_out is the combinational result; word_out_q is a registered copy.
module sub_word #(
   parameter int regSize = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [regSize-1:0] word_in,
   output logic [regSize-1:0] word_out,
   output logic [regSize-1:0] word_out_q
);

   localparam int NB = regSize / 8;

   // Forward AES S-box, indexed by input byte value.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic [regSize-1:0] word_out_d;

   // One independent S-box lookup per byte lane; lanes never interact.
   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
   end

   // Next value of the registered copy is simply the combinational result.
   always_comb begin
      word_out_d = word_out;
   end

   // Pipeline register; async reset clears it without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_out_q <= '0;
      end else begin
         word_out_q <= word_out_d;
      end
   end

endmodule

// File: tb/tb_sub_word.sv
// Bench for sub_word. Reference S-box is derived arithmetically
// (GF(2^8) multiplicative inverse followed by the AES affine map).
module tb_sub_word;

   logic        clk;
   logic        rst_n;
   logic [31:0] word_in;
   logic [31:0] word_out;
   logic [31:0] word_out_q;

   int checks;
   int errors;

   logic [7:0] ref_sbox [256];

   sub_word #(.regSize(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .word_in    (word_in),
      .word_out   (word_out),
      .word_out_q (word_out_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] model_sbox(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      if (a != 8'h00) begin
         for (int c = 1; c < 256; c++) begin
            if (gf_mul(a, 8'(c)) == 8'h01) inv = 8'(c);
         end
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] w);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) r[8*l +: 8] = ref_sbox[w[8*l +: 8]];
      return r;
   endfunction

   task automatic test_reset();
      logic [31:0] w;
      rst_n = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         w = $urandom;
         word_in = w;
         @(posedge clk);
         #1;
         checks++;
         if (word_out_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_q actual=%h required=%h", word_out_q, 32'h0);
         end
         checks++;
         if (word_out !== model_word(w)) begin
            errors++;
            $display("FAIL reset_comb_tracks actual=%h required=%h", word_out, model_word(w));
         end
      end
   endtask

   task automatic test_vectors();
      logic [31:0] vin [6];
      logic [31:0] vexp [6];
      vin[0] = 32'h00000101; vexp[0] = 32'h63637c7c;
      vin[1] = 32'h03030707; vexp[1] = 32'h7b7bc5c5;
      vin[2] = 32'h0f0f1f1f; vexp[2] = 32'h7676c0c0;
      vin[3] = 32'h3f3f7f7f; vexp[3] = 32'h7575d2d2;
      vin[4] = 32'h53ff0001; vexp[4] = 32'hed16637c;
      vin[5] = 32'hff53017f; vexp[5] = 32'h16ed7cd2;
      for (int n = 0; n < 6; n++) begin
         word_in = vin[n];
         #10;
         checks++;
         if (word_out !== vexp[n]) begin
            errors++;
            $display("FAIL vector%0d actual=%h required=%h", n, word_out, vexp[n]);
         end
         checks++;
         if (word_out !== model_word(vin[n])) begin
            errors++;
            $display("FAIL vector_model%0d actual=%h required=%h", n, word_out, model_word(vin[n]));
         end
      end
   endtask

   task automatic test_register();
      logic [31:0] w;
      logic [31:0] prev;
      @(negedge clk);
      rst_n = 1'b1;
      word_in = 32'h53ff0001;
      #1;
      checks++;
      if (word_out_q !== 32'h0) begin
         errors++;
         $display("FAIL release_hold actual=%h required=%h", word_out_q, 32'h0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (word_out_q !== 32'hed16637c) begin
         errors++;
         $display("FAIL first_capture actual=%h required=%h", word_out_q, 32'hed16637c);
      end
      prev = 32'h53ff0001;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         w = $urandom;
         word_in = w;
         #1;
         checks++;
         if (word_out_q !== model_word(prev)) begin
            errors++;
            $display("FAIL q_latency actual=%h required=%h", word_out_q, model_word(prev));
         end
         @(posedge clk);
         #1;
         checks++;
         if (word_out_q !== model_word(w)) begin
            errors++;
            $display("FAIL q_capture actual=%h required=%h", word_out_q, model_word(w));
         end
         prev = w;
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (word_out_q !== 32'h0) begin
         errors++;
         $display("FAIL async_clear actual=%h required=%h", word_out_q, 32'h0);
      end
      word_in = 32'h0f0f1f1f;
      #1;
      checks++;
      if (word_out !== 32'h7676c0c0) begin
         errors++;
         $display("FAIL comb_during_reset actual=%h required=%h", word_out, 32'h7676c0c0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (word_out_q !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold actual=%h required=%h", word_out_q, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (word_out_q !== 32'h7676c0c0) begin
         errors++;
         $display("FAIL post_reset_capture actual=%h required=%h", word_out_q, 32'h7676c0c0);
      end
   endtask

   task automatic test_exhaustive();
      logic [31:0] base;
      logic [31:0] w;
      for (int l = 0; l < 4; l++) begin
         for (int b = 0; b < 4; b++) base[8*b +: 8] = 8'(8'h11 * (b + 1) + $urandom_range(0, 15));
         for (int v = 0; v < 256; v++) begin
            w = base;
            w[8*l +: 8] = 8'(v);
            word_in = w;
            #1;
            checks++;
            if (word_out !== model_word(w)) begin
               errors++;
               $display("FAIL sweep_lane%0d in=%h actual=%h required=%h", l, w, word_out, model_word(w));
            end
         end
      end
   endtask

   task automatic test_random_comb();
      logic [31:0] w;
      for (int n = 0; n < 200; n++) begin
         w = $urandom;
         word_in = w;
         #1;
         checks++;
         if (word_out !== model_word(w)) begin
            errors++;
            $display("FAIL random_comb in=%h actual=%h required=%h", w, word_out, model_word(w));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      word_in = 32'h0;
      for (int a = 0; a < 256; a++) ref_sbox[a] = model_sbox(8'(a));
      test_reset();
      test_vectors();
      test_register();
      test_async_reset();
      test_exhaustive();
      test_random_comb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
